// File: rtl/write_back_pipe_if.sv
// MEM/WB bus between the memory stage, the write-back register and its consumers
// (register-file write port and forwarding unit).
interface write_back_pipe_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_CNT  = 32
);
    logic               i_valid;
    logic               i_stall;
    logic               i_flush;
    logic [NB_DATA-1:0] i_ALUresult;
    logic [NB_DATA-1:0] i_reg_read;
    logic [NB_DATA-1:0] i_pc_link;
    logic [1:0]         i_wb_sel;
    logic [1:0]         i_load_size;
    logic               i_load_unsigned;
    logic [1:0]         i_addr_lsb;
    logic [NB_ADDR-1:0] i_reg2write;
    logic               i_regWrite;

    logic [NB_DATA-1:0] o_write_data;
    logic [NB_ADDR-1:0] o_reg2write;
    logic               o_regWrite;
    logic               o_valid;
    logic [NB_CNT-1:0]  o_retired;

    modport master (
        output i_valid, i_stall, i_flush, i_ALUresult, i_reg_read, i_pc_link,
               i_wb_sel, i_load_size, i_load_unsigned, i_addr_lsb,
               i_reg2write, i_regWrite,
        input  o_write_data, o_reg2write, o_regWrite, o_valid, o_retired
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_ALUresult, i_reg_read, i_pc_link,
               i_wb_sel, i_load_size, i_load_unsigned, i_addr_lsb,
               i_reg2write, i_regWrite,
        output o_write_data, o_reg2write, o_regWrite, o_valid, o_retired
    );
endinterface

// File: rtl/write_back_pipe.sv
// Registered MEM/WB stage: selects ALU / extracted load / link data, qualifies the
// register write (never to r0), handles stall/flush and counts retired instructions.
module write_back_pipe #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_CNT  = 32
) (
    input logic             i_clk,
    input logic             i_reset,
    write_back_pipe_if.slave wb
);

    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    logic [7:0]         load_byte;
    logic [15:0]        load_half;
    logic [NB_DATA-1:0] load_data;
    logic [NB_DATA-1:0] sel_data;
    logic               reg_write_qual;

    logic [NB_DATA-1:0] data_q;
    logic [NB_ADDR-1:0] reg_q;
    logic               we_q;
    logic               valid_q;
    logic [NB_CNT-1:0]  retired_q;

    // Little-endian lane extraction from the low word; halfword ignores addr bit 0.
    always_comb begin
        load_byte = wb.i_reg_read[7:0];
        case (wb.i_addr_lsb)
            2'd0:    load_byte = wb.i_reg_read[7:0];
            2'd1:    load_byte = wb.i_reg_read[15:8];
            2'd2:    load_byte = wb.i_reg_read[23:16];
            default: load_byte = wb.i_reg_read[31:24];
        endcase
        load_half = wb.i_addr_lsb[1] ? wb.i_reg_read[31:16] : wb.i_reg_read[15:0];
    end

    always_comb begin
        load_data = wb.i_reg_read;
        case (wb.i_load_size)
            SIZE_BYTE: load_data = wb.i_load_unsigned
                                 ? {{(NB_DATA-8){1'b0}}, load_byte}
                                 : {{(NB_DATA-8){load_byte[7]}}, load_byte};
            SIZE_HALF: load_data = wb.i_load_unsigned
                                 ? {{(NB_DATA-16){1'b0}}, load_half}
                                 : {{(NB_DATA-16){load_half[15]}}, load_half};
            default:   load_data = wb.i_reg_read;
        endcase
    end

    // Reserved select code falls back to the ALU result.
    always_comb begin
        sel_data = wb.i_ALUresult;
        case (wb.i_wb_sel)
            SEL_MEM:  sel_data = load_data;
            SEL_LINK: sel_data = wb.i_pc_link;
            default:  sel_data = wb.i_ALUresult;
        endcase
    end

    assign reg_write_qual = wb.i_regWrite & wb.i_valid & (wb.i_reg2write != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            data_q    <= '0;
            reg_q     <= '0;
            we_q      <= 1'b0;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else if (wb.i_flush) begin
            data_q  <= '0;
            reg_q   <= '0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
        end else if (!wb.i_stall) begin
            // Data is captured even when the write is suppressed; consumers key on we only.
            data_q  <= sel_data;
            reg_q   <= wb.i_reg2write;
            we_q    <= reg_write_qual;
            valid_q <= wb.i_valid;
            if (wb.i_valid) begin
                retired_q <= retired_q + NB_CNT'(1);
            end
        end
    end

    assign wb.o_write_data = data_q;
    assign wb.o_reg2write  = reg_q;
    assign wb.o_regWrite   = we_q;
    assign wb.o_valid      = valid_q;
    assign wb.o_retired    = retired_q;

endmodule

// File: tb/tb_write_back_pipe.sv
// Directed bench for write_back_pipe with a 4-bit retired counter so wrap is reachable.
module tb_write_back_pipe;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_CNT  = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [NB_CNT-1:0] exp_ret;

    write_back_pipe_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) bus ();

    write_back_pipe #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .wb      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [1:0] sel, input logic [1:0] size,
                         input logic uns, input logic [1:0] lsb, input logic [4:0] rd,
                         input logic we, input logic [31:0] alu, input logic [31:0] rr,
                         input logic [31:0] pc);
        bus.i_valid         = valid;
        bus.i_wb_sel        = sel;
        bus.i_load_size     = size;
        bus.i_load_unsigned = uns;
        bus.i_addr_lsb      = lsb;
        bus.i_reg2write     = rd;
        bus.i_regWrite      = we;
        bus.i_ALUresult     = alu;
        bus.i_reg_read      = rr;
        bus.i_pc_link       = pc;
    endtask

    // Load vectors: size, unsigned, lsb, expected data.
    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lsb;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads[9];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_ret  = '0;
        loads[0] = '{2'b00, 1'b0, 2'd3, 32'hFFFF_FF87};
        loads[1] = '{2'b00, 1'b1, 2'd0, 32'h0000_0021};
        loads[2] = '{2'b01, 1'b0, 2'd2, 32'hFFFF_8765};
        loads[3] = '{2'b01, 1'b0, 2'd3, 32'hFFFF_8765};
        loads[4] = '{2'b01, 1'b0, 2'd0, 32'h0000_4321};
        loads[5] = '{2'b00, 1'b0, 2'd1, 32'h0000_0043};
        loads[6] = '{2'b00, 1'b1, 2'd2, 32'h0000_0065};
        loads[7] = '{2'b10, 1'b0, 2'd1, 32'h8765_4321};
        loads[8] = '{2'b11, 1'b1, 2'd2, 32'h8765_4321};

        rst = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 1'b0, 2'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_data",    bus.o_write_data, 32'h0);
        check("rst_reg",     32'(bus.o_reg2write), 32'h0);
        check("rst_we",      32'(bus.o_regWrite), 32'h0);
        check("rst_valid",   32'(bus.o_valid), 32'h0);
        check("rst_retired", 32'(bus.o_retired), 32'h0);
        rst = 1'b0;

        drive(1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'd10, 1'b1, 32'h1234_5678, 32'h0, 32'h0);
        tick();
        exp_ret++;
        check("alu_data",    bus.o_write_data, 32'h1234_5678);
        check("alu_reg",     32'(bus.o_reg2write), 32'd10);
        check("alu_we",      32'(bus.o_regWrite), 32'h1);
        check("alu_valid",   32'(bus.o_valid), 32'h1);
        check("alu_retired", 32'(bus.o_retired), 32'(exp_ret));

        // Asynchronous reset between edges clears at once.
        #3;
        rst = 1'b1;
        #1;
        exp_ret = '0;
        check("async_rst_data",    bus.o_write_data, 32'h0);
        check("async_rst_we",      32'(bus.o_regWrite), 32'h0);
        check("async_rst_retired", 32'(bus.o_retired), 32'h0);
        rst = 1'b0;
        tick();
        exp_ret++;
        check("post_rst_data",    bus.o_write_data, 32'h1234_5678);
        check("post_rst_retired", 32'(bus.o_retired), 32'(exp_ret));

        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 2'b01, loads[i].size, loads[i].uns, loads[i].lsb, 5'd5, 1'b1,
                  32'hDEAD_BEEF, 32'h8765_4321, 32'h0);
            tick();
            exp_ret++;
            check($sformatf("load%0d_data", i), bus.o_write_data, loads[i].exp);
        end
        check("load_retired", 32'(bus.o_retired), 32'(exp_ret));

        drive(1'b1, 2'b11, 2'b00, 1'b0, 2'd0, 5'd9, 1'b1, 32'hCAFE_F00D, 32'h1111_1111, 32'h2222_2222);
        tick();
        exp_ret++;
        check("sel_rsvd_data", bus.o_write_data, 32'hCAFE_F00D);

        drive(1'b1, 2'b10, 2'b00, 1'b0, 2'd0, 5'd31, 1'b1, 32'h0, 32'h0, 32'h0040_0008);
        tick();
        exp_ret++;
        check("link_data", bus.o_write_data, 32'h0040_0008);
        check("link_reg",  32'(bus.o_reg2write), 32'd31);
        check("link_we",   32'(bus.o_regWrite), 32'h1);

        drive(1'b1, 2'b10, 2'b00, 1'b0, 2'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0040_000C);
        tick();
        exp_ret++;
        check("r0_we",      32'(bus.o_regWrite), 32'h0);
        check("r0_data",    bus.o_write_data, 32'h0040_000C);
        check("r0_reg",     32'(bus.o_reg2write), 32'h0);
        check("r0_retired", 32'(bus.o_retired), 32'(exp_ret));

        drive(1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'd12, 1'b0, 32'h0BAD_F00D, 32'h0, 32'h0);
        tick();
        exp_ret++;
        check("nowe_we",      32'(bus.o_regWrite), 32'h0);
        check("nowe_valid",   32'(bus.o_valid), 32'h1);
        check("nowe_retired", 32'(bus.o_retired), 32'(exp_ret));

        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'(i + 1), 1'b1, 32'h1000 + 32'(i), 32'h0, 32'h0);
            tick();
            check("stall_data",    bus.o_write_data, 32'h0BAD_F00D);
            check("stall_reg",     32'(bus.o_reg2write), 32'd12);
            check("stall_we",      32'(bus.o_regWrite), 32'h0);
            check("stall_retired", 32'(bus.o_retired), 32'(exp_ret));
        end

        bus.i_flush = 1'b1;
        tick();
        check("stflush_data",    bus.o_write_data, 32'h0);
        check("stflush_we",      32'(bus.o_regWrite), 32'h0);
        check("stflush_valid",   32'(bus.o_valid), 32'h0);
        check("stflush_retired", 32'(bus.o_retired), 32'(exp_ret));
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;

        drive(1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'd7, 1'b1, 32'hA5A5_A5A5, 32'h0, 32'h0);
        tick();
        exp_ret++;
        check("cap_data", bus.o_write_data, 32'hA5A5_A5A5);
        bus.i_flush = 1'b1;
        tick();
        check("flush_data",    bus.o_write_data, 32'h0);
        check("flush_reg",     32'(bus.o_reg2write), 32'h0);
        check("flush_retired", 32'(bus.o_retired), 32'(exp_ret));
        bus.i_flush = 1'b0;

        drive(1'b0, 2'b00, 2'b00, 1'b0, 2'd0, 5'd3, 1'b1, 32'h0000_0055, 32'h0, 32'h0);
        tick();
        check("bubble_data",    bus.o_write_data, 32'h55);
        check("bubble_reg",     32'(bus.o_reg2write), 32'd3);
        check("bubble_we",      32'(bus.o_regWrite), 32'h0);
        check("bubble_valid",   32'(bus.o_valid), 32'h0);
        check("bubble_retired", 32'(bus.o_retired), 32'(exp_ret));

        // exp_ret is 15 here; one more valid capture wraps to 0.
        drive(1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'd3, 1'b1, 32'h66, 32'h0, 32'h0);
        tick();
        exp_ret++;
        check("wrap_retired", 32'(bus.o_retired), 32'h0);

        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'd4, 1'b1, 32'(i), 32'h0, 32'h0);
            tick();
        end
        check("cnt17_retired", 32'(bus.o_retired), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 2'b00, 1'b0, 2'd0, 5'd4, 1'b1, 32'(i), 32'h0, 32'h0);
            tick();
        end
        check("cnt_invalid_retired", 32'(bus.o_retired), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
